pipe_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipeline (FETCH, DEC, EXE, MEM, WB).
- Tracks in-flight destination registers from EXE through WB in a shift register.
- Generates stall, bubble and flush controls, and forwarding selects and data for the two DEC source operands.
- Replaces the fixed, hazard-free stage wiring of the current top level and supports a configurable number of post-DEC stages.

---
 rtl/pipe_hazard_unit_pkg.sv | 21 ++
 rtl/pipe_hazard_unit_if.sv | 45 ++++
 rtl/pipe_hazard_unit_fwd_mux.sv | 61 ++++++
 rtl/pipe_hazard_unit.sv | 72 +++++++
 tb/tb_pipe_hazard_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: slot record,
// forward-select encoding and datapath defaults.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 4;
  // Slot rd field is sized for the widest supported register file; narrower
  // register addresses are zero-extended on entry.
  localparam int RD_MAX_W   = 8;
  localparam int SEL_W      = 3;

  localparam logic [SEL_W-1:0] FWD_RF = '0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                needs_wb;
    logic                is_load;
  } slot_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// DEC-side bundle between the pipeline datapath and the hazard unit.
// master = datapath, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int POST_STAGES = 3,
  parameter int PERF_W      = 16
);
  logic                          dec_valid;
  logic [REG_AW-1:0]             dec_rs1;
  logic [REG_AW-1:0]             dec_rs2;
  logic                          dec_use_rs1;
  logic                          dec_use_rs2;
  logic [REG_AW-1:0]             dec_rd;
  logic                          dec_needs_wb;
  logic                          dec_is_load;
  logic [DATA_W-1:0]             rf_rs1_val;
  logic [DATA_W-1:0]             rf_rs2_val;
  logic [POST_STAGES*DATA_W-1:0] stage_data;
  logic                          br_taken;

  logic                          stall;
  logic                          bubble;
  logic                          flush_fd;
  logic [2:0]                    fwd_sel_rs1;
  logic [2:0]                    fwd_sel_rs2;
  logic [DATA_W-1:0]             op1_val;
  logic [DATA_W-1:0]             op2_val;
  logic [PERF_W-1:0]             perf_stalls;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_needs_wb, dec_is_load, rf_rs1_val, rf_rs2_val, stage_data, br_taken,
    input  stall, bubble, flush_fd, fwd_sel_rs1, fwd_sel_rs2, op1_val, op2_val,
           perf_stalls
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_needs_wb, dec_is_load, rf_rs1_val, rf_rs2_val, stage_data, br_taken,
    output stall, bubble, flush_fd, fwd_sel_rs1, fwd_sel_rs2, op1_val, op2_val,
           perf_stalls
  );

endinterface

// File: rtl/pipe_hazard_unit_fwd_mux.sv
// Per-source priority search over the in-flight slots plus operand select.
// Build option PIPE_FWD_EN: defined = forward, undefined = stall until RF holds the value.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int POST_STAGES = 3,
  parameter int R0_ZERO     = 1
) (
  input  slot_t [POST_STAGES-1:0]      slots,
  input  logic [REG_AW-1:0]            rs,
  input  logic                         use_rs,
  input  logic [DATA_W-1:0]            rf_val,
  input  logic [POST_STAGES*DATA_W-1:0] stage_data,
  output logic [SEL_W-1:0]             fwd_sel,
  output logic [DATA_W-1:0]            op_val,
  output logic                         hazard
);

`ifdef PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic                   rs_zero;
  logic [POST_STAGES-1:0] match;
  logic [SEL_W-1:0]       pri_sel;
  logic [DATA_W-1:0]      pri_val;
  logic                   load_use;
  logic                   early_match;

  assign rs_zero = (R0_ZERO != 0) && (rs == '0);

  for (genvar k = 0; k < POST_STAGES; k++) begin : g_match
    assign match[k] = use_rs & slots[k].valid & slots[k].needs_wb &
                      (slots[k].rd == RD_MAX_W'(rs)) & ~rs_zero;
  end

  // Walk oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    pri_sel = FWD_RF;
    pri_val = rf_val;
    for (int k = POST_STAGES-1; k >= 0; k--) begin
      if (match[k]) begin
        pri_sel = SEL_W'(k + 1);
        pri_val = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign load_use    = match[0] & slots[0].is_load;
  // WB slot excluded: the register file is write-first, so RF already sees it.
  assign early_match = |match[POST_STAGES-2:0];

  assign fwd_sel = FWD_EN ? pri_sel  : FWD_RF;
  assign op_val  = FWD_EN ? pri_val  : rf_val;
  assign hazard  = FWD_EN ? load_use : early_match;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline; tracks EXE..WB
// destinations in a slot shift register. Forwarding enabled by macro PIPE_FWD_EN.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int POST_STAGES = 3,
  parameter int R0_ZERO     = 1,
  parameter int PERF_W      = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_unit_if.slave bus
);

  slot_t [POST_STAGES-1:0] slots;
  slot_t                   dec_slot;
  logic                    haz_rs1, haz_rs2;
  logic                    hazard, stall, issue;
  logic [PERF_W-1:0]       perf_q;

  fwd_mux #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .POST_STAGES(POST_STAGES), .R0_ZERO(R0_ZERO)
  ) u_fwd_rs1 (
    .slots(slots), .rs(bus.dec_rs1), .use_rs(bus.dec_use_rs1),
    .rf_val(bus.rf_rs1_val), .stage_data(bus.stage_data),
    .fwd_sel(bus.fwd_sel_rs1), .op_val(bus.op1_val), .hazard(haz_rs1)
  );

  fwd_mux #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .POST_STAGES(POST_STAGES), .R0_ZERO(R0_ZERO)
  ) u_fwd_rs2 (
    .slots(slots), .rs(bus.dec_rs2), .use_rs(bus.dec_use_rs2),
    .rf_val(bus.rf_rs2_val), .stage_data(bus.stage_data),
    .fwd_sel(bus.fwd_sel_rs2), .op_val(bus.op2_val), .hazard(haz_rs2)
  );

  // A taken branch squashes DEC anyway, so it overrides any stall.
  assign hazard = bus.dec_valid & (haz_rs1 | haz_rs2);
  assign stall  = hazard & ~bus.br_taken;
  assign issue  = bus.dec_valid & ~stall & ~bus.br_taken;

  assign bus.stall       = stall;
  assign bus.bubble      = hazard | bus.br_taken;
  assign bus.flush_fd    = bus.br_taken;
  assign bus.perf_stalls = perf_q;

  always_comb begin
    dec_slot          = '0;
    dec_slot.valid    = issue;
    dec_slot.rd       = RD_MAX_W'(bus.dec_rd);
    dec_slot.needs_wb = bus.dec_needs_wb;
    dec_slot.is_load  = bus.dec_is_load;
    if (!issue) dec_slot = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else begin
      slots[0] <= dec_slot;
      for (int k = 1; k < POST_STAGES; k++) slots[k] <= slots[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      perf_q <= '0;
    else if (stall && perf_q != '1) perf_q <= perf_q + PERF_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit; expectations come from a slot model
// of the pipeline, covering both PIPE_FWD_EN build options.
module tb_pipe_hazard_unit;
  import pipe_pkg::*;

  localparam int DW = 32, AW = 4, PS = 3, PW = 4;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [DW-1:0] RF1 = 32'hAAAA_0001, RF2 = 32'hBBBB_0002;

  typedef struct {
    bit v; logic [AW-1:0] rs1, rs2; bit u1, u2; logic [AW-1:0] rd; bit wb, ld, br;
  } ins_t;

  typedef struct {
    bit stall, bubble, flush; logic [2:0] sel1, sel2;
    logic [DW-1:0] op1, op2; int perf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .POST_STAGES(PS), .PERF_W(PW)) bus();

  pipe_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .POST_STAGES(PS), .R0_ZERO(1), .PERF_W(PW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] sd [PS];
  bit            m_v [PS];
  bit            m_wb[PS];
  bit            m_ld[PS];
  logic [AW-1:0] m_rd[PS];
  int            m_perf;
  exp_t          sb[$];
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(bit v, logic [AW-1:0] rs1, logic [AW-1:0] rs2, bit u1, bit u2,
                              logic [AW-1:0] rd, bit wb, bit ld, bit br);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
    i.rd = rd; i.wb = wb; i.ld = ld; i.br = br;
    return i;
  endfunction

  // Expected select/operand for one DEC source from the model's in-flight slots.
  task automatic src_eval(input logic [AW-1:0] rs, input bit en, input logic [DW-1:0] rf,
                          output logic [2:0] sel, output logic [DW-1:0] op, output bit haz);
    sel = 3'd0; op = rf; haz = 1'b0;
    if (en && rs != 0) begin
      for (int k = 0; k < PS; k++) begin
        if (m_v[k] && m_wb[k] && m_rd[k] == rs) begin
          if (FWD) begin
            if (sel == 3'd0) begin
              sel = 3'(k + 1); op = sd[k];
              if (k == 0 && m_ld[0]) haz = 1'b1;
            end
          end else if (k < PS-1) begin
            haz = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input ins_t i, output bit issued);
    exp_t e, g;
    bit h1, h2, h;
    bus.dec_valid = i.v;   bus.dec_rs1 = i.rs1;   bus.dec_rs2 = i.rs2;
    bus.dec_use_rs1 = i.u1; bus.dec_use_rs2 = i.u2; bus.dec_rd = i.rd;
    bus.dec_needs_wb = i.wb; bus.dec_is_load = i.ld; bus.br_taken = i.br;
    src_eval(i.rs1, i.u1, RF1, e.sel1, e.op1, h1);
    src_eval(i.rs2, i.u2, RF2, e.sel2, e.op2, h2);
    h = i.v & (h1 | h2);
    e.stall = h & ~i.br; e.bubble = h | i.br; e.flush = i.br; e.perf = m_perf;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk("stall", 32'(bus.stall), 32'(g.stall));
    chk("bubble", 32'(bus.bubble), 32'(g.bubble));
    chk("flush_fd", 32'(bus.flush_fd), 32'(g.flush));
    chk("fwd_sel_rs1", 32'(bus.fwd_sel_rs1), 32'(g.sel1));
    chk("fwd_sel_rs2", 32'(bus.fwd_sel_rs2), 32'(g.sel2));
    chk("op1_val", bus.op1_val, g.op1);
    chk("op2_val", bus.op2_val, g.op2);
    chk("perf_stalls", 32'(bus.perf_stalls), 32'(g.perf));
    issued = i.v & ~g.stall & ~i.br;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < PS; k++) m_v[k] = 1'b0;
      m_perf = 0;
    end else begin
      for (int k = PS-1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_wb[k] = m_wb[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
      end
      m_v[0] = issued; m_wb[0] = i.wb; m_ld[0] = i.ld; m_rd[0] = i.rd;
      if (g.stall && m_perf < (1 << PW) - 1) m_perf++;
    end
    @(negedge clk);
  endtask

  // Hold an instruction in DEC until it issues or is squashed by a branch.
  task automatic present(input ins_t i);
    bit done;
    int n;
    done = 1'b0; n = 0;
    while (!done && n < 8) begin
      cycle(i, done);
      if (i.br) done = 1'b1;
      n++;
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit d;
    for (int c = 0; c < n; c++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), d);
  endtask

  initial begin
    sd[0] = 32'h0000_0011; sd[1] = 32'hDEAD_BEEF; sd[2] = 32'h3333_0002;
    bus.stage_data = {sd[2], sd[1], sd[0]};
    bus.rf_rs1_val = RF1; bus.rf_rs2_val = RF2;
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_use_rs1 = 0;
    bus.dec_use_rs2 = 0; bus.dec_rd = 0; bus.dec_needs_wb = 0; bus.dec_is_load = 0;
    bus.br_taken = 0;
    for (int k = 0; k < PS; k++) begin m_v[k] = 0; m_wb[k] = 0; m_ld[k] = 0; m_rd[k] = 0; end
    m_perf = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("perf_rst", 32'(bus.perf_stalls), 32'd0);
    chk("stall_rst", 32'(bus.stall), 32'd0);
    @(negedge clk);
    idle(1);

    // ADD r3 then SUB r3,r4
    present(mk(1, 1, 2, 1, 1, 3, 1, 0, 0));
    present(mk(1, 3, 4, 1, 1, 6, 1, 0, 0));
    idle(3);
    // LW r5 then consumer of r5 on rs2
    present(mk(1, 0, 0, 0, 0, 5, 1, 1, 0));
    present(mk(1, 1, 5, 1, 1, 7, 1, 0, 0));
    idle(3);
    // load-use coinciding with taken branch
    present(mk(1, 0, 0, 0, 0, 6, 1, 1, 0));
    present(mk(1, 6, 6, 1, 1, 8, 1, 0, 1));
    idle(3);
    // r0 writes, then r0 consumer
    for (int n = 0; n < 3; n++) present(mk(1, 1, 1, 1, 0, 0, 1, 0, 0));
    present(mk(1, 0, 0, 1, 1, 9, 1, 0, 0));
    idle(3);
    // ADD r2 then immediate consumer
    present(mk(1, 1, 1, 1, 0, 2, 1, 0, 0));
    present(mk(1, 2, 1, 1, 1, 10, 1, 0, 0));
    idle(3);
    // matching but unused source
    present(mk(1, 1, 1, 0, 0, 7, 1, 0, 0));
    present(mk(1, 7, 7, 0, 0, 11, 1, 0, 0));
    idle(3);
    // two writers of r8: youngest must win on rs2
    present(mk(1, 0, 0, 0, 0, 8, 1, 0, 0));
    present(mk(1, 0, 0, 0, 0, 8, 1, 0, 0));
    present(mk(1, 1, 8, 1, 1, 12, 1, 0, 0));
    idle(3);
    // non-writing producer must not cause a hazard
    present(mk(1, 0, 0, 0, 0, 4, 0, 1, 0));
    present(mk(1, 4, 4, 1, 1, 13, 1, 0, 0));
    idle(3);
    // saturate the stall counter
    for (int n = 0; n < 20; n++) begin
      present(mk(1, 0, 0, 0, 0, 9, 1, 1, 0));
      present(mk(1, 9, 1, 1, 0, 12, 1, 0, 0));
    end
    #1 chk("perf_sat", 32'(bus.perf_stalls), 32'd15);
    @(negedge clk);
    // reset while stalled
    present(mk(1, 0, 0, 0, 0, 5, 1, 1, 0));
    begin
      bit d;
      rst = 1'b1;
      cycle(mk(1, 5, 5, 1, 1, 6, 1, 0, 0), d);
      rst = 1'b0;
    end
    #1 chk("perf_after_rst", 32'(bus.perf_stalls), 32'd0);
    @(negedge clk);
    present(mk(1, 5, 5, 1, 1, 6, 1, 0, 0));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
